reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Downstream of the clock/reset generator. Runs on the 50 MHz system clk and its
//  synchronised reset. Waits for the USB 48 MHz PLL lock to be stable, then releases
//  the per-subsystem resets in order: SRAM, then Ethernet PHY/MAC, then USB FIFO.
//  Raises sys_ready once all are released. Re-runs the whole sequence on lock loss
//  or on a soft-reset pulse.
// PARAMETERS
//  CNT_W          24      width of the shared hold counter
//  LOCK_STABLE    1024    consecutive synchronised-locked cycles required
//  SRAM_HOLD      16      cycles spent in ST_SRAM before sram_rst_n deasserts
//  ETH_HOLD       500000  cycles spent in ST_ETH before eth_rst_n deasserts (10 ms PHY hold)
//  USB_HOLD       16      cycles spent in ST_USB before usb_rst_n deasserts
// PORTS
//  clk          in   1  50 MHz system clock
//  rst_n        in   1  reset, asynchronous assert, active low
//  pll_locked   in   1  USB PLL lock; asynchronous to clk
//  soft_rst     in   1  single-cycle pulse, synchronous to clk; restarts the sequence
//  sram_rst_n   out  1  SRAM controller reset, active low
//  eth_rst_n    out  1  Ethernet PHY/MAC reset, active low
//  usb_rst_n    out  1  USB FIFO interface reset, active low
//  sys_ready    out  1  high when all subsystems are out of reset
//  seq_state    out  3  current FSM state, for debug
// BEHAVIOUR
//  - Clock: one, clk. Reset: rst_n, asynchronous, active low.
//  - While rst_n is low: state=ST_LOCK, cnt=0, and all outputs are 0 (seq_state=0).
//  - pll_locked passes through a 2-flop synchroniser to give lk_s. An input first
//    sampled high at edge 0 is seen by the FSM at edge 2.
//  - States: ST_LOCK=0, ST_SRAM=1, ST_ETH=2, ST_USB=3, ST_READY=4. Values 5-7 are
//    illegal and go to ST_LOCK.
//  - ST_LOCK: all resets stay low.
//    - cnt increments on each edge where lk_s=1; it clears to 0 when lk_s=0.
//    - On the edge where cnt==LOCK_STABLE-1 and lk_s=1: go to ST_SRAM, cnt=0.
//  - ST_SRAM, ST_ETH, ST_USB:
//    - cnt increments every edge.
//    - On the edge where cnt==HOLD-1: go to the next state and clear cnt.
//    - Outputs are registered and change on that same transition edge:
//      - entering ST_ETH sets sram_rst_n=1
//      - entering ST_USB sets eth_rst_n=1
//      - entering ST_READY sets usb_rst_n=1 and sys_ready=1
//  - ST_READY: stays there and holds the outputs; cnt is frozen at 0.
//  - Abort (priority, highest first):
//    1. rst_n low.
//    2. soft_rst=1: next edge goes to ST_LOCK with cnt=0 and all outputs 0. This
//       applies in every state, including in ST_LOCK mid-count.
//    3. lk_s=0 in any state other than ST_LOCK: same as soft_rst.
//  - Deassert order is guaranteed: sram_rst_n, then eth_rst_n, then usb_rst_n.
//    All three outputs go low on the same edge.
//  - Hold values of 0 are illegal; elaboration-time check. Each HOLD value must be
//    less than 2**CNT_W.
//  - There are no glitches: every output comes directly from a flop.
// STRUCTURE
//  - Package reset_seq_pkg: state encodings ST_* as localparams, and the
//    default hold constants.
//  - Sub-module sync_2ff: generic 2-flop synchroniser with async active-low clear,
//    used for pll_locked.
//  - The FSM and one shared CNT_W-bit counter live in the top module.
// TESTING (LOCK_STABLE=4, SRAM_HOLD=3, ETH_HOLD=5, USB_HOLD=2)
//  1. Reset with pll_locked=0 -> all outputs 0 and seq_state=0 indefinitely. No
//     output toggles.
//  2. pll_locked first sampled high at edge 0 and held ->
//     - ST_SRAM after edge 5
//     - sram_rst_n=1 after edge 8
//     - eth_rst_n=1 after edge 13
//     - usb_rst_n=1 and sys_ready=1 after edge 15
//  3. pll_locked glitches low for one cycle while lk counting is at cnt=2 ->
//     cnt clears and the full LOCK_STABLE count restarts. sram_rst_n release is
//     delayed to match.
//  4. In ST_ETH (sram_rst_n=1), pll_locked drops -> 2 edges later lk_s=0. On the next
//     edge all outputs are 0 and seq_state=0. On relock, scenario 2 timing repeats.
//  5. soft_rst pulse while in ST_READY -> next edge all outputs 0 and seq_state=0.
//     Full sequence reruns with pll_locked still high: sram release 7 edges later.
//  6. rst_n asserted asynchronously mid-ST_USB -> outputs drop immediately, with no
//     clk edge. After release the sequence restarts from ST_LOCK.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default hold
// constants and the per-state output decode.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOCK  = 3'd0,
    ST_SRAM  = 3'd1,
    ST_ETH   = 3'd2,
    ST_USB   = 3'd3,
    ST_READY = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_CNT_W       = 24;
  localparam int unsigned DEF_LOCK_STABLE = 1024;
  localparam int unsigned DEF_SRAM_HOLD   = 16;
  localparam int unsigned DEF_ETH_HOLD    = 500000;
  localparam int unsigned DEF_USB_HOLD    = 16;

  typedef struct packed {
    logic sram_rst_n;
    logic eth_rst_n;
    logic usb_rst_n;
    logic sys_ready;
  } rst_out_t;

  // Each reset is released once the FSM has moved past the state that holds it.
  function automatic rst_out_t outputs_for(seq_state_e st);
    rst_out_t o;
    o = '0;
    case (st)
      ST_ETH:   o.sram_rst_n = 1'b1;
      ST_USB: begin
        o.sram_rst_n = 1'b1;
        o.eth_rst_n  = 1'b1;
      end
      ST_READY: o = '1;
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low clear.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Waits for a stable USB PLL lock, then releases SRAM, Ethernet and USB resets
// in order; restarts on lock loss or soft reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int unsigned SRAM_HOLD   = DEF_SRAM_HOLD,
  parameter int unsigned ETH_HOLD    = DEF_ETH_HOLD,
  parameter int unsigned USB_HOLD    = DEF_USB_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       sram_rst_n,
  output logic       eth_rst_n,
  output logic       usb_rst_n,
  output logic       sys_ready,
  output logic [2:0] seq_state
);

  if (LOCK_STABLE == 0 || SRAM_HOLD == 0 || ETH_HOLD == 0 || USB_HOLD == 0) begin : g_zero_hold
    $error("reset_sequencer: hold and lock counts must be non-zero");
  end

  if (64'(LOCK_STABLE) >= (64'd1 << CNT_W) || 64'(SRAM_HOLD) >= (64'd1 << CNT_W) ||
      64'(ETH_HOLD) >= (64'd1 << CNT_W) || 64'(USB_HOLD) >= (64'd1 << CNT_W)) begin : g_wide_hold
    $error("reset_sequencer: hold count does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] SRAM_LAST = CNT_W'(SRAM_HOLD - 1);
  localparam logic [CNT_W-1:0] ETH_LAST  = CNT_W'(ETH_HOLD - 1);
  localparam logic [CNT_W-1:0] USB_LAST  = CNT_W'(USB_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             lk_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rst_out_t         out_q, out_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOCK;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (soft_rst || (!lk_s && state_q != ST_LOCK)) begin
      state_d = ST_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOCK: begin
          if (!lk_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_SRAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_SRAM: begin
          if (cnt_q == SRAM_LAST) begin
            state_d = ST_ETH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_ETH: begin
          if (cnt_q == ETH_LAST) begin
            state_d = ST_USB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_USB: begin
          if (cnt_q == USB_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_READY: cnt_d = '0;
        default: begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode from the next state so they register on the transition edge.
  always_comb begin
    out_d = outputs_for(state_d);
  end

  assign sram_rst_n = out_q.sram_rst_n;
  assign eth_rst_n  = out_q.eth_rst_n;
  assign usb_rst_n  = out_q.usb_rst_n;
  assign sys_ready  = out_q.sys_ready;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with short hold constants.
module tb_reset_sequencer;

  localparam int LOCK_STABLE = 4;
  localparam int SRAM_HOLD   = 3;
  localparam int ETH_HOLD    = 5;
  localparam int USB_HOLD    = 2;
  localparam int T_NOM       = 1 + LOCK_STABLE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       sram_rst_n, eth_rst_n, usb_rst_n, sys_ready;
  logic [2:0] seq_state;

  typedef struct {
    int         k;
    logic [6:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  reset_sequencer #(
    .CNT_W       (24),
    .LOCK_STABLE (LOCK_STABLE),
    .SRAM_HOLD   (SRAM_HOLD),
    .ETH_HOLD    (ETH_HOLD),
    .USB_HOLD    (USB_HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .sram_rst_n (sram_rst_n),
    .eth_rst_n  (eth_rst_n),
    .usb_rst_n  (usb_rst_n),
    .sys_ready  (sys_ready),
    .seq_state  (seq_state)
  );

  always #10 clk = ~clk;

  // Expected {seq_state, sys_ready, usb, eth, sram} after edge k when ST_SRAM is entered at edge t.
  function automatic logic [6:0] exp_seq(int k, int t);
    if (k < t)                                  return 7'b000_0000;
    if (k < t + SRAM_HOLD)                      return 7'b001_0000;
    if (k < t + SRAM_HOLD + ETH_HOLD)           return 7'b010_0001;
    if (k < t + SRAM_HOLD + ETH_HOLD + USB_HOLD) return 7'b011_0011;
    return 7'b100_1111;
  endfunction

  function automatic logic [6:0] observed();
    return {seq_state, sys_ready, usb_rst_n, eth_rst_n, sram_rst_n};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [6:0] obs;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_rst = 1'b0;
    for (int k = 0; k < 14; k++) sb_q.push_back('{k, 7'b000_0000});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 4) rst_n = 1'b1;
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL reset edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL reset edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sequence();
    sb_t e;
    logic [6:0] obs;
    do_reset();
    for (int k = 0; k < 18; k++) sb_q.push_back('{k, exp_seq(k, T_NOM)});
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      pll_locked = 1'b1;
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sequence edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL sequence edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
  endtask

  // One-cycle low sample at edge 2 reaches the FSM at edge 4, when cnt==2.
  task automatic test_lock_glitch();
    sb_t e;
    logic [6:0] obs;
    do_reset();
    for (int k = 0; k < 14; k++) sb_q.push_back('{k, exp_seq(k, 8)});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      pll_locked = (k != 2);
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL glitch edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL glitch edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_loss();
    sb_t e;
    logic [6:0] obs;
    do_reset();
    for (int k = 0; k < 32; k++)
      sb_q.push_back('{k, (k < 12) ? exp_seq(k, T_NOM) : exp_seq(k, 15 + T_NOM)});
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      pll_locked = !(k >= 10 && k < 15);
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL lock_loss edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL lock_loss edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
  endtask

  // Soft reset from ST_READY, then again twice with the second landing mid lock count.
  task automatic test_soft_rst();
    sb_t e;
    logic [6:0] obs;
    logic [6:0] x;
    do_reset();
    for (int k = 0; k < 52; k++) begin
      if (k < 17)      x = exp_seq(k, T_NOM);
      else if (k < 33) x = exp_seq(k, 17 + 4);
      else             x = exp_seq(k, 35 + 4);
      sb_q.push_back('{k, x});
    end
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      pll_locked = 1'b1;
      soft_rst = (k == 17 || k == 33 || k == 35);
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL soft_rst edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL soft_rst edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
    @(negedge clk);
    soft_rst = 1'b0;
  endtask

  task automatic test_async_reset();
    sb_t e;
    logic [6:0] obs;
    do_reset();
    for (int k = 0; k < 14; k++) sb_q.push_back('{k, exp_seq(k, T_NOM)});
    sb_q.push_back('{-1, 7'b000_0000});
    for (int k = 0; k < 17; k++) sb_q.push_back('{k, exp_seq(k, T_NOM)});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      pll_locked = 1'b1;
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL async_pre edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL async_pre edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
    #4;
    rst_n = 1'b0;
    #1;
    obs = observed();
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL async_drop: scoreboard empty, got %b", obs);
    end else begin
      e = sb_q.pop_front();
      if (obs !== e.exp) $display("FAIL async_drop: got %b expected %b", obs, e.exp);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      pll_locked = 1'b1;
      @(posedge clk);
      #1;
      obs = observed();
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL async_post edge %0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.exp) $display("FAIL async_post edge %0d: got %b expected %b", e.k, obs, e.exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lock_glitch();
    test_lock_loss();
    test_soft_rst();
    test_async_reset();
    n_total++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
